gamepad_reader: RTL and testbench

Serial game-controller reader that produces the 8-bit button vector consumed by the GuyBox UI state machine and game logic. It periodically latches an external shift-register pad, clocks out 8 active-low button bits, and filters them through a two-frame debounce. It publishes a stable button vector, per-button press pulses and a frame strobe, all synchronous to the system clock.

---
 rtl/gamepad_reader.sv | 160 ++++++++++++++++
 tb/tb_gamepad_reader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gamepad_reader.sv
`default_nettype none
// ============================================================================
// Module   : gamepad_reader
// Purpose  : Polls a serial shift-register game pad and publishes a two-frame
//            debounced button vector, press pulses and a frame strobe.
// Revision : 1.0 - initial release
// ============================================================================
module gamepad_reader #(
    parameter int CLK_DIV     = 600,
    parameter int POLL_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] buttons,
    output logic [7:0] pressed,
    output logic       frame_valid
);

    localparam int c_PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int c_DW = $clog2(2 * CLK_DIV);

    localparam logic [c_PW-1:0] c_POLL_LAST  = c_PW'(POLL_CYCLES - 1);
    localparam logic [c_DW-1:0] c_HALF_LAST  = c_DW'(CLK_DIV - 1);
    localparam logic [c_DW-1:0] c_LATCH_LAST = c_DW'(2 * CLK_DIV - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_LOW   = 3'd2;
    localparam logic [2:0] S_HIGH  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [c_PW-1:0] r_poll_cnt;
    logic [c_DW-1:0] r_div_cnt;
    logic [2:0]      r_bit_idx;
    logic            r_sync1;
    logic            r_sync2;
    logic [7:0]      r_raw_serial;
    logic [7:0]      r_prev;
    logic [7:0]      r_buttons;
    logic [7:0]      r_pressed;
    logic            r_frame_valid;
    logic            r_pad_latch;
    logic            r_pad_clk;

    logic            w_poll_done;
    logic            w_half_last;
    logic            w_latch_last;
    logic            w_pad_latch_d;
    logic            w_pad_clk_d;
    logic            w_enter_done;
    logic [7:0]      w_raw_frame;

    assign w_poll_done  = en && (r_poll_cnt == c_POLL_LAST);
    assign w_half_last  = (r_div_cnt == c_HALF_LAST);
    assign w_latch_last = (r_div_cnt == c_LATCH_LAST);

    // Serial order A,B,C,Start,Up,Down,Left,Right -> {Start,C,B,A,Right,Left,Down,Up}
    assign w_raw_frame = {r_raw_serial[3:0], r_raw_serial[7:4]};

    // State register; pad strobes are registered from the next state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pad_latch <= 1'b0;
            r_pad_clk   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pad_latch <= w_pad_latch_d;
            r_pad_clk   <= w_pad_clk_d;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_poll_done)  w_state_nxt = S_LATCH;
            S_LATCH: if (w_latch_last) w_state_nxt = S_LOW;
            S_LOW:   if (w_half_last)  w_state_nxt = S_HIGH;
            S_HIGH:  if (w_half_last)  w_state_nxt = (r_bit_idx == 3'd7) ? S_DONE : S_LOW;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pad_latch_d = (w_state_nxt == S_LATCH);
        w_pad_clk_d   = (w_state_nxt == S_HIGH);
        w_enter_done  = (w_state_nxt == S_DONE);
    end

    // Timing counters, bit index and serial capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_poll_cnt   <= '0;
            r_div_cnt    <= '0;
            r_bit_idx    <= 3'd0;
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_raw_serial <= 8'd0;
        end else begin
            r_sync1 <= pad_data;
            r_sync2 <= r_sync1;

            if (r_state == S_IDLE && en)
                r_poll_cnt <= w_poll_done ? '0 : r_poll_cnt + c_PW'(1);
            else if (r_state != S_IDLE)
                r_poll_cnt <= '0;

            if ((r_state == S_LATCH || r_state == S_LOW || r_state == S_HIGH) &&
                (w_state_nxt == r_state))
                r_div_cnt <= r_div_cnt + c_DW'(1);
            else
                r_div_cnt <= '0;

            // The 7 -> 0 wrap coincides with leaving HIGH for DONE
            if (r_state == S_IDLE)
                r_bit_idx <= 3'd0;
            else if (r_state == S_HIGH && w_half_last)
                r_bit_idx <= r_bit_idx + 3'd1;

            if (r_state == S_LOW && w_half_last)
                r_raw_serial[r_bit_idx] <= ~r_sync2;
        end
    end

    // Two-frame debounce, published on the edge into DONE
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev        <= 8'd0;
            r_buttons     <= 8'd0;
            r_pressed     <= 8'd0;
            r_frame_valid <= 1'b0;
        end else begin
            r_pressed     <= 8'd0;
            r_frame_valid <= 1'b0;
            if (w_enter_done) begin
                r_frame_valid <= 1'b1;
                r_prev        <= w_raw_frame;
                if (w_raw_frame == r_prev) begin
                    r_buttons <= w_raw_frame;
                    r_pressed <= w_raw_frame & ~r_buttons;
                end
            end
        end
    end

    assign pad_latch   = r_pad_latch;
    assign pad_clk     = r_pad_clk;
    assign buttons     = r_buttons;
    assign pressed     = r_pressed;
    assign frame_valid = r_frame_valid;

endmodule
`default_nettype wire

// File: tb/tb_gamepad_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_gamepad_reader
// Purpose  : Directed self-checking bench for gamepad_reader with a pad model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gamepad_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       pad_data = 1'b1;
    logic       pad_latch;
    logic       pad_clk;
    logic [7:0] buttons;
    logic [7:0] pressed;
    logic       frame_valid;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int stray  = 0;
    int last_fv_cyc = 0;

    logic [7:0] btn = 8'h00;
    logic [7:0] sr = 8'hFF;
    logic       pclk_q = 1'b0;

    gamepad_reader #(.CLK_DIV(4), .POLL_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .en(en), .pad_data(pad_data),
        .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons(buttons),
        .pressed(pressed), .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    // Pad: parallel load while latched, shift on pad_clk rise, low = pressed
    always @(negedge clk) begin
        if (pad_latch === 1'b1)
            sr = ~{btn[3:0], btn[7:4]};
        else if (pad_clk === 1'b1 && pclk_q == 1'b0)
            sr = {1'b1, sr[7:1]};
        pclk_q   = pad_clk;
        pad_data = sr[0];
    end

    task automatic step();
        @(negedge clk);
        cyc++;
        if (pressed !== 8'h00 && frame_valid !== 1'b1) stray++;
    endtask

    task automatic wait_frame(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (frame_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL frame_timeout: frame_valid not seen, required within 300 cycles");
        end
    endtask

    task automatic test_reset();
        int lat_bad, clk_bad, fv_bad, rises;
        logic exp_l, exp_c, exp_f, pq;
        rst = 1'b0; en = 1'b1; btn = 8'h00;
        repeat (3) step();
        checks++;
        if ({pad_latch, pad_clk, buttons, pressed, frame_valid} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required all zero",
                     {pad_latch, pad_clk, buttons, pressed, frame_valid});
        end
        rst = 1'b1;
        cyc = 0;
        lat_bad = 0; clk_bad = 0; fv_bad = 0; rises = 0; pq = 1'b0;
        for (int k = 0; k <= 95; k++) begin
            if (k > 0) step();
            exp_l = (k >= 16 && k < 24);
            exp_c = (k >= 24 && k < 88 && ((k - 24) % 8) >= 4);
            exp_f = (k == 88);
            if (pad_latch !== exp_l) lat_bad++;
            if (pad_clk !== exp_c) clk_bad++;
            if (frame_valid !== exp_f) fv_bad++;
            if (pad_clk === 1'b1 && !pq) rises++;
            pq = pad_clk;
        end
        last_fv_cyc = 88;
        checks++;
        if (lat_bad != 0) begin
            errors++;
            $display("FAIL reset_latch_wave: %0d wrong cycles, required 0 (high 16..23)", lat_bad);
        end
        checks++;
        if (clk_bad != 0) begin
            errors++;
            $display("FAIL reset_padclk_wave: %0d wrong cycles, required 0", clk_bad);
        end
        checks++;
        if (fv_bad != 0) begin
            errors++;
            $display("FAIL reset_frame_valid: %0d wrong cycles, required 0 (only cycle 88)", fv_bad);
        end
        checks++;
        if (rises != 8) begin
            errors++;
            $display("FAIL reset_padclk_pulses: got %0d, required 8", rises);
        end
    endtask

    task automatic test_glitch();
        logic ok;
        btn = 8'h01;
        wait_frame(ok);
        checks++;
        if (cyc - last_fv_cyc != 89) begin
            errors++;
            $display("FAIL frame_period: got %0d, required 89", cyc - last_fv_cyc);
        end
        checks++;
        if (buttons !== 8'h00 || pressed !== 8'h00) begin
            errors++;
            $display("FAIL glitch_frame1: buttons=%h pressed=%h, required 00 00", buttons, pressed);
        end
        btn = 8'h00;
        wait_frame(ok);
        checks++;
        if (buttons !== 8'h00 || pressed !== 8'h00) begin
            errors++;
            $display("FAIL glitch_frame2: buttons=%h pressed=%h, required 00 00", buttons, pressed);
        end
    endtask

    task automatic test_press();
        logic ok;
        btn = 8'h90;
        wait_frame(ok);
        checks++;
        if (buttons !== 8'h00 || pressed !== 8'h00) begin
            errors++;
            $display("FAIL press_frame1: buttons=%h pressed=%h, required 00 00", buttons, pressed);
        end
        wait_frame(ok);
        checks++;
        if (buttons !== 8'h90) begin
            errors++;
            $display("FAIL press_frame2_buttons: got %h, required 90", buttons);
        end
        checks++;
        if (pressed !== 8'h90) begin
            errors++;
            $display("FAIL press_frame2_pulse: got %h, required 90", pressed);
        end
        step();
        checks++;
        if (pressed !== 8'h00 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL press_pulse_width: pressed=%h fv=%b, required 00 0", pressed, frame_valid);
        end
        wait_frame(ok);
        checks++;
        if (buttons !== 8'h90 || pressed !== 8'h00) begin
            errors++;
            $display("FAIL press_frame3: buttons=%h pressed=%h, required 90 00", buttons, pressed);
        end
    endtask

    task automatic test_release();
        logic ok;
        btn = 8'h80;
        wait_frame(ok);
        checks++;
        if (buttons !== 8'h90 || pressed !== 8'h00) begin
            errors++;
            $display("FAIL release_frame1: buttons=%h pressed=%h, required 90 00", buttons, pressed);
        end
        wait_frame(ok);
        checks++;
        if (buttons !== 8'h80 || pressed !== 8'h00) begin
            errors++;
            $display("FAIL release_frame2: buttons=%h pressed=%h, required 80 00", buttons, pressed);
        end
    endtask

    task automatic test_enable();
        logic ok, pq, seen;
        int rises, found;
        rises = 0; pq = 1'b0; seen = 1'b0; found = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (pad_clk === 1'b1 && !pq) rises++;
            pq = pad_clk;
            if (rises == 3 && pad_clk === 1'b0) break;
        end
        checks++;
        if (rises != 3 || pad_clk !== 1'b0) begin
            errors++;
            $display("FAIL enable_reach_bit3: rises=%0d, required 3", rises);
        end
        en = 1'b0;
        wait_frame(ok);
        checks++;
        if (buttons !== 8'h80) begin
            errors++;
            $display("FAIL enable_frame_buttons: got %h, required 80", buttons);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            if (pad_latch !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL enable_hold: pad_latch rose with en low, required stay 0");
        end
        en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (pad_latch === 1'b1) begin
                found = k;
                break;
            end
        end
        checks++;
        if (found != 16) begin
            errors++;
            $display("FAIL enable_resume: latch after %0d cycles, required 16", found);
        end
        wait_frame(ok);
    endtask

    task automatic test_reset_mid();
        logic pq;
        int rises, first_fv;
        rises = 0; pq = 1'b0; first_fv = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (pad_clk === 1'b1 && !pq) rises++;
            pq = pad_clk;
            if (rises == 6) break;
        end
        checks++;
        if (rises != 6 || pad_clk !== 1'b1) begin
            errors++;
            $display("FAIL midreset_reach_bit5: rises=%0d, required 6", rises);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({pad_latch, pad_clk, frame_valid} !== 3'b000 || buttons !== 8'h00 || pressed !== 8'h00) begin
            errors++;
            $display("FAIL midreset_outputs: latch=%b clk=%b fv=%b buttons=%h pressed=%h, required all 0",
                     pad_latch, pad_clk, frame_valid, buttons, pressed);
        end
        step();
        step();
        rst = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (frame_valid === 1'b1) begin
                first_fv = k;
                break;
            end
        end
        checks++;
        if (first_fv != 88) begin
            errors++;
            $display("FAIL midreset_first_frame: frame_valid at %0d, required 88", first_fv);
        end
        checks++;
        if (buttons !== 8'h00) begin
            errors++;
            $display("FAIL midreset_buttons: got %h, required 00", buttons);
        end
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b1;
        test_reset();
        test_glitch();
        test_press();
        test_release();
        test_enable();
        test_reset_mid();
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL pressed_outside_done: %0d cycles, required 0", stray);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
